// File: rtl/mmm_pkg.sv
// rtl/mmm_pkg.sv - shared constants, clog2 helper and tag type for the multiplier arbiter
package mmm_pkg;

  localparam int IDW     = 90;
  localparam int ODW     = 181;
  localparam int LAT_MUL = 3;
  // Tag id field sized for the largest supported requester count (8).
  localparam int IW_MAX  = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic              valid;
    logic [IW_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/mmm_nlp_90b.sv
// rtl/mmm_nlp_90b.sv - pipelined 90x90 multiplier core, res = a*b+carry, 3-edge latency
module mmm_nlp_90b
  import mmm_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  input  logic [IDW-1:0] a,
  input  logic [IDW-1:0] b,
  input  logic           carry,
  output logic [ODW-1:0] res
);

  logic [IDW-1:0] a_q;
  logic [IDW-1:0] b_q;
  logic           c_q;
  logic [ODW-1:0] p_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      p_q <= '0;
      res <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
      c_q <= carry;
      p_q <= ODW'(a_q) * ODW'(b_q) + ODW'(c_q);
      res <= p_q;
    end
  end

endmodule

// File: rtl/mmm_rr_arb.sv
// rtl/mmm_rr_arb.sv - combinational round-robin grant with its rotating pointer register
module mmm_rr_arb
  import mmm_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic            adv,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] ptr;

  // Scan downward so the last hit kept is the first valid at or above ptr.
  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    if (en) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        j = (int'(ptr) + k) % NREQ;
        if (req[j]) begin
          gnt     = '0;
          gnt[j]  = 1'b1;
          gnt_idx = IW'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mmm_mul_arb.sv
// rtl/mmm_mul_arb.sv - shares one pipelined multiplier core between NREQ tagged requesters
module mmm_mul_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 90,
  parameter int ODW  = 181,
  parameter int LAT  = 3,
  parameter int IW   = mmm_pkg::clog2(NREQ)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              i_en,
  input  logic [NREQ-1:0]                   i_req_valid,
  output logic [NREQ-1:0]                   o_req_ready,
  input  logic [NREQ*IDW-1:0]               i_req_a,
  input  logic [NREQ*IDW-1:0]               i_req_b,
  input  logic [NREQ-1:0]                   i_req_carry,
  output logic [IDW-1:0]                    o_m_a,
  output logic [IDW-1:0]                    o_m_b,
  output logic                              o_m_carry,
  input  logic [ODW-1:0]                    i_m_res,
  output logic                              o_rsp_valid,
  output logic [IW-1:0]                     o_rsp_id,
  output logic [ODW-1:0]                    o_rsp_res,
  output logic                              o_busy,
  output logic [mmm_pkg::clog2(LAT+3)-1:0]  o_inflight
);

  localparam int CW = mmm_pkg::clog2(LAT + 3);
  localparam int TW = mmm_pkg::IW_MAX;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            acc;
  logic [CW-1:0]   cnt;
  mmm_pkg::tag_t   tags [LAT+1];

  // Grants are masked during reset so requests are ignored while rstn is low.
  mmm_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (i_req_valid),
    .en      (i_en & rstn),
    .adv     (acc),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign acc         = |gnt;
  assign o_req_ready = gnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_m_a     <= '0;
      o_m_b     <= '0;
      o_m_carry <= 1'b0;
    end else if (acc) begin
      o_m_a     <= i_req_a[int'(gnt_idx)*IDW +: IDW];
      o_m_b     <= i_req_b[int'(gnt_idx)*IDW +: IDW];
      o_m_carry <= i_req_carry[gnt_idx];
    end
  end

  // Tag stage LAT lines up with the core result, which is captured one edge later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= LAT; i++) tags[i] <= '0;
    end else begin
      tags[0].valid <= acc;
      tags[0].id    <= TW'(gnt_idx);
      for (int i = 1; i <= LAT; i++) tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_res   <= '0;
    end else begin
      o_rsp_valid <= tags[LAT].valid;
      if (tags[LAT].valid) begin
        o_rsp_id  <= tags[LAT].id[IW-1:0];
        o_rsp_res <= i_m_res;
      end
    end
  end

  always_comb begin
    cnt = CW'(o_rsp_valid);
    for (int i = 0; i <= LAT; i++) cnt = cnt + CW'(tags[i].valid);
  end

  assign o_inflight = cnt;
  assign o_busy     = |cnt;

endmodule

// File: tb/tb_mmm_mul_arb.sv
// tb/tb_mmm_mul_arb.sv - scoreboard bench for mmm_mul_arb driving the real multiplier core
module tb_mmm_mul_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 90;
  localparam int ODW  = 181;

  logic              clk;
  logic              rstn;
  logic              i_en;
  logic [NREQ-1:0]   i_req_valid;
  logic [NREQ-1:0]   o_req_ready;
  logic [NREQ*IDW-1:0] i_req_a;
  logic [NREQ*IDW-1:0] i_req_b;
  logic [NREQ-1:0]   i_req_carry;
  logic [IDW-1:0]    o_m_a;
  logic [IDW-1:0]    o_m_b;
  logic              o_m_carry;
  logic [ODW-1:0]    i_m_res;
  logic              o_rsp_valid;
  logic [1:0]        o_rsp_id;
  logic [ODW-1:0]    o_rsp_res;
  logic              o_busy;
  logic [2:0]        o_inflight;

  typedef struct {
    logic [1:0]     id;
    logic [ODW-1:0] res;
  } exp_t;

  exp_t           q[$];
  logic [ODW-1:0] exp_res [NREQ];
  int             n_cmp = 0;
  int             n_bad = 0;
  int             n_rsp = 0;
  int             base;

  mmm_mul_arb dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_en        (i_en),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_req_carry (i_req_carry),
    .o_m_a       (o_m_a),
    .o_m_b       (o_m_b),
    .o_m_carry   (o_m_carry),
    .i_m_res     (i_m_res),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_res   (o_rsp_res),
    .o_busy      (o_busy),
    .o_inflight  (o_inflight)
  );

  mmm_nlp_90b u_core (
    .clk   (clk),
    .rstn  (rstn),
    .a     (o_m_a),
    .b     (o_m_b),
    .carry (o_m_carry),
    .res   (i_m_res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [ODW-1:0] act, input logic [ODW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn && o_rsp_valid) begin
      n_rsp++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got id %0d res %0h expected no response", o_rsp_id, o_rsp_res);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_id", ODW'(o_rsp_id), ODW'(e.id));
        chk("rsp_res", o_rsp_res, e.res);
      end
    end
  end

  task automatic set_op(input int r, input logic [IDW-1:0] a, input logic [IDW-1:0] b,
                        input logic c, input logic [ODW-1:0] e);
    i_req_a[r*IDW +: IDW] = a;
    i_req_b[r*IDW +: IDW] = b;
    i_req_carry[r]        = c;
    exp_res[r]            = e;
  endtask

  // Called at posedge+1; drives valid, checks the grant, queues the expected result.
  task automatic step(input logic [3:0] v, input logic [3:0] eg, input string nm);
    exp_t e;
    i_req_valid = v;
    #1;
    chk(nm, ODW'(o_req_ready), ODW'(eg));
    for (int r = 0; r < NREQ; r++) begin
      if (eg[r]) begin
        e.id  = 2'(r);
        e.res = exp_res[r];
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((q.size() != 0 || o_busy) && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({nm, "_busy"}, ODW'(o_busy), '0);
    chk({nm, "_pending"}, ODW'(q.size()), '0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, ODW'(o_req_ready), '0);
    chk({nm, "_m_a"}, ODW'(o_m_a), '0);
    chk({nm, "_m_b"}, ODW'(o_m_b), '0);
    chk({nm, "_m_carry"}, ODW'(o_m_carry), '0);
    chk({nm, "_rsp_valid"}, ODW'(o_rsp_valid), '0);
    chk({nm, "_rsp_id"}, ODW'(o_rsp_id), '0);
    chk({nm, "_rsp_res"}, o_rsp_res, '0);
    chk({nm, "_busy"}, ODW'(o_busy), '0);
    chk({nm, "_inflight"}, ODW'(o_inflight), '0);
  endtask

  initial begin
    rstn        = 1'b0;
    i_en        = 1'b1;
    i_req_valid = 4'b1111;
    i_req_a     = '0;
    i_req_b     = '0;
    i_req_carry = '0;
    for (int r = 0; r < NREQ; r++) exp_res[r] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    i_req_valid = '0;
    rstn        = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 2: 3*5+1 = 16.
    set_op(2, 90'd3, 90'd5, 1'b1, 181'd16);
    step(4'b0100, 4'b0100, "t1_grant");
    i_req_valid = '0;
    chk("t1_m_a", ODW'(o_m_a), 181'd3);
    chk("t1_m_b", ODW'(o_m_b), 181'd5);
    chk("t1_m_carry", ODW'(o_m_carry), 181'd1);
    chk("t1_inflight0", ODW'(o_inflight), 181'd1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      chk("t1_inflight", ODW'(o_inflight), 181'd1);
    end
    chk("t1_m_a_hold", ODW'(o_m_a), 181'd3);
    @(posedge clk);
    #1;
    chk("t1_inflight_end", ODW'(o_inflight), '0);
    chk("t1_busy_end", ODW'(o_busy), '0);
    chk("t1_rsp_count", ODW'(n_rsp), 181'd1);

    // Reset to bring ptr back to 0, then all four requesters continuously.
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    set_op(0, 90'd7, 90'd9, 1'b0, 181'd63);
    set_op(1, 90'd10, 90'd11, 1'b1, 181'd111);
    set_op(2, 90'd100, 90'd200, 1'b0, 181'd20000);
    set_op(3, 90'd255, 90'd255, 1'b1, 181'd65026);
    for (int n = 0; n < 2; n++) begin
      step(4'b1111, 4'b0001, "t2_g0");
      step(4'b1111, 4'b0010, "t2_g1");
      step(4'b1111, 4'b0100, "t2_g2");
      step(4'b1111, 4'b1000, "t2_g3");
    end
    i_req_valid = '0;
    drain("t2");

    // Full-width operands: (2^90-1)^2 + 1 = 2^180 - 2^91 + 2.
    set_op(0, {IDW{1'b1}}, {IDW{1'b1}}, 1'b1,
           (181'd1 << 180) - (181'd1 << 91) + 181'd2);
    step(4'b0001, 4'b0001, "t3_grant");
    i_req_valid = '0;
    drain("t3");

    // Put ptr at 2, then requesters 1 and 3 compete.
    set_op(1, 90'd2, 90'd3, 1'b0, 181'd6);
    step(4'b0010, 4'b0010, "t4_setup");
    set_op(3, 90'd4, 90'd5, 1'b1, 181'd21);
    set_op(1, 90'd6, 90'd7, 1'b0, 181'd42);
    step(4'b1010, 4'b1000, "t4_first3");
    step(4'b1010, 4'b0010, "t4_then1");
    step(4'b1111, 4'b0100, "t4_ptr2");
    i_req_valid = '0;
    drain("t4");

    // Grant enable dropped after three grants.
    base = n_rsp;
    step(4'b1111, 4'b1000, "t5_g3");
    step(4'b1111, 4'b0001, "t5_g0");
    step(4'b1111, 4'b0010, "t5_g1");
    i_en = 1'b0;
    step(4'b1111, 4'b0000, "t5_off0");
    step(4'b1111, 4'b0000, "t5_off1");
    step(4'b1111, 4'b0000, "t5_off2");
    i_req_valid = '0;
    i_en        = 1'b1;
    drain("t5");
    chk("t5_rsp_count", ODW'(n_rsp - base), 181'd3);

    // Reset while two operations are in flight.
    step(4'b0100, 4'b0100, "t6_a");
    step(4'b0010, 4'b0010, "t6_b");
    i_req_valid = 4'b1111;
    rstn        = 1'b0;
    q.delete();
    base = n_rsp;
    #1;
    chk_reset_vals("t6_rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(4'b1111, 4'b0001, "t6_after");
    i_req_valid = '0;
    drain("t6");
    chk("t6_rsp_count", ODW'(n_rsp - base), 181'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
